// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out receiver.
// The PARITY state is always declared; it is only reachable when the
// receiver is built with SIPO_PARITY_CHECK_EN defined.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;

  // Bit-counter width able to hold 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: collects a start-framed bit stream into
// WIDTH-bit words and presents them on a valid/ready output register with
// sticky overrun reporting and a restart (frame_abort) pulse.
// Optional build macro: SIPO_PARITY_CHECK_EN adds an even-parity bit after
// each word and reports parity_err alongside par_out.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_en,
  input  logic             start,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_abort,
  output logic             busy,
  output logic             parity_err
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             abort_nxt;
  logic             restart;
`ifdef SIPO_PARITY_CHECK_EN
  logic             word_perr;
`endif

  // Insert one bit at the entry end of the shifter.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                 input logic b);
    if (MSB_FIRST) return {s[WIDTH-2:0], b};
    else           return {b, s[WIDTH-1:1]};
  endfunction

  // Compile-time guard on the minimum frame width.
  if (WIDTH < WIDTH_MIN) begin : g_width_check
    $error("sipo_rx: WIDTH must be at least WIDTH_MIN");
  end

  // State, bit counter and shifter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // Next-state logic: framing, shifting, restart detection, word completion.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    abort_nxt = 1'b0;
    word_done = 1'b0;
    shifted   = shift_in(sreg, serial_in);
    first_bit = shift_in('0, serial_in);
    word      = shifted;
    restart   = serial_en && start;
`ifdef SIPO_PARITY_CHECK_EN
    word_perr = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (restart) begin
          sreg_nxt  = first_bit;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (restart) begin
          abort_nxt = 1'b1;
          sreg_nxt  = first_bit;
          cnt_nxt   = CW'(1);
        end else if (serial_en) begin
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
            sreg_nxt  = shifted;
            cnt_nxt   = CW'(WIDTH);
            state_nxt = PARITY;
`else
            word_done = 1'b1;
            word      = shifted;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            sreg_nxt = shifted;
            cnt_nxt  = cnt + CW'(1);
          end
        end
      end
`ifdef SIPO_PARITY_CHECK_EN
      PARITY: begin
        if (restart) begin
          abort_nxt = 1'b1;
          sreg_nxt  = first_bit;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end else if (serial_en) begin
          word_done = 1'b1;
          word      = sreg;
          word_perr = (^sreg) ^ serial_in;
          sreg_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sreg_nxt  = '0;
      end
    endcase
  end

  // Output register: load on completion when the slot is free or being
  // drained this edge, otherwise drop the word and flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_out     <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= abort_nxt;
      if (word_done && (!out_valid || out_ready)) begin
        par_out   <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (word_done && out_valid && !out_ready) overrun <= 1'b1;
      else if (clr_err)                          overrun <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  // Parity flag travels with par_out and only changes when a word loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else if (word_done && (!out_valid || out_ready)) parity_err <= word_perr;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: two instances (MSB-first and LSB-first)
// share all inputs and are compared against a frame-level reference model.
module tb_sipo_rx;

  localparam int unsigned W = 4;
`ifdef SIPO_PARITY_CHECK_EN
  localparam int unsigned FRAME_LEN = W + 1;
`else
  localparam int unsigned FRAME_LEN = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b0, serial_en = 1'b0, start = 1'b0;
  logic out_ready = 1'b0, clr_err = 1'b0;

  logic [W-1:0] par_m, par_l;
  logic valid_m, valid_l, ovr_m, ovr_l, abort_m, abort_l;
  logic busy_m, busy_l, perr_m, perr_l;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state
  bit           q[$];
  bit           in_frame;
  logic [W-1:0] e_par_m, e_par_l;
  logic         e_valid, e_ovr, e_abort, e_perr;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_en(serial_en),
    .start(start), .out_ready(out_ready), .clr_err(clr_err),
    .par_out(par_m), .out_valid(valid_m), .overrun(ovr_m),
    .frame_abort(abort_m), .busy(busy_m), .parity_err(perr_m));

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_en(serial_en),
    .start(start), .out_ready(out_ready), .clr_err(clr_err),
    .par_out(par_l), .out_valid(valid_l), .overrun(ovr_l),
    .frame_abort(abort_l), .busy(busy_l), .parity_err(perr_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_frame = 1'b0;
    e_par_m = '0; e_par_l = '0;
    e_valid = 1'b0; e_ovr = 1'b0; e_abort = 1'b0; e_perr = 1'b0;
  endtask

  // One clock edge of behaviour, evaluated from the inputs held across it.
  task automatic model_edge();
    bit           done = 1'b0;
    bit           ovr_set = 1'b0;
    logic [W-1:0] wm = '0, wl = '0;
    bit           p = 1'b0;
    e_abort = 1'b0;
    if (serial_en) begin
      if (start) begin
        if (in_frame) e_abort = 1'b1;
        q.delete();
        q.push_back(serial_in);
        in_frame = 1'b1;
      end else if (in_frame) begin
        q.push_back(serial_in);
      end
    end
    if (in_frame && q.size() == FRAME_LEN) begin
      done = 1'b1;
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = q[i];
        wl[i]     = q[i];
      end
      foreach (q[i]) p ^= q[i];
      q.delete();
      in_frame = 1'b0;
    end
    if (done) begin
      if (!e_valid || out_ready) begin
        e_par_m = wm; e_par_l = wl; e_valid = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
        e_perr = p;
`endif
      end else begin
        ovr_set = 1'b1;
      end
    end else if (e_valid && out_ready) begin
      e_valid = 1'b0;
    end
    if (ovr_set) e_ovr = 1'b1;
    else if (clr_err) e_ovr = 1'b0;
  endtask

  task automatic check_all();
    chk("par_msb",   32'(par_m),   32'(e_par_m));
    chk("par_lsb",   32'(par_l),   32'(e_par_l));
    chk("valid_msb", 32'(valid_m), 32'(e_valid));
    chk("valid_lsb", 32'(valid_l), 32'(e_valid));
    chk("overrun",   32'(ovr_m),   32'(e_ovr));
    chk("overrun_l", 32'(ovr_l),   32'(e_ovr));
    chk("abort",     32'(abort_m), 32'(e_abort));
    chk("abort_l",   32'(abort_l), 32'(e_abort));
    chk("busy",      32'(busy_m),  32'(in_frame));
    chk("busy_l",    32'(busy_l),  32'(in_frame));
    chk("perr",      32'(perr_m),  32'(e_perr));
  endtask

  task automatic step(input logic se, input logic si, input logic st,
                      input logic rdy, input logic clr);
    serial_en = se; serial_in = si; start = st; out_ready = rdy; clr_err = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Send a 4-bit frame, first bit = b[3]; parity bit appended when enabled.
  task automatic send_frame(input logic [3:0] b, input int unsigned gap,
                            input logic rdy_mid, input logic rdy_last,
                            input logic pbit);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[3-i], (i == 0), (i == 3 && FRAME_LEN == W) ? rdy_last : rdy_mid, 1'b0);
      if (i < 3) for (int g = 0; g < int'(gap); g++) step(1'b0, 1'b0, 1'b0, rdy_mid, 1'b0);
    end
`ifdef SIPO_PARITY_CHECK_EN
    step(1'b1, pbit, 1'b0, rdy_last, 1'b0);
`else
    if (pbit) ; // parity bit is not transmitted in this build
`endif
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_valid", 32'(valid_m), 32'h0);
    chk("rst_par",   32'(par_m),   32'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic frame 1,0,0,1
    send_frame(4'b1001, 0, 1'b1, 1'b1, 1'b0);
    chk("basic_par",   32'(par_m),   32'h9);
    chk("basic_valid", 32'(valid_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_drop",  32'(valid_m), 32'h0);

    // Gapped frame; busy through the gaps
    send_frame(4'b1001, 2, 1'b1, 1'b1, 1'b0);
    chk("gap_par_l", 32'(par_l), 32'h9);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: two frames, consumer stalled
    send_frame(4'b1010, 0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 0, 1'b0, 1'b0, 1'b0);
    chk("ovr_par",  32'(par_m), 32'hA);
    chk("ovr_parl", 32'(par_l), 32'h5);
    chk("ovr_flag", 32'(ovr_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr",  32'(ovr_m), 32'h0);

    // Back-to-back handoff on the completion edge
    send_frame(4'b0011, 1, 1'b0, 1'b1, 1'b0);
    chk("b2b_par",   32'(par_m),   32'h3);
    chk("b2b_valid", 32'(valid_m), 32'h1);
    chk("b2b_ovr",   32'(ovr_m),   32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart after two bits
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    serial_en = 1'b1; serial_in = 1'b0; start = 1'b1;
    @(posedge clk); model_edge(); #1; check_all();
    chk("restart_abort", 32'(abort_m), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_once", 32'(abort_m), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    chk("restart_par", 32'(par_m), 32'h6);

    // Parity checks
`ifdef SIPO_PARITY_CHECK_EN
    send_frame(4'b1001, 0, 1'b1, 1'b1, 1'b0);
    chk("par_ok",  32'(perr_m), 32'h0);
    send_frame(4'b1011, 0, 1'b1, 1'b1, 1'b0);
    chk("par_bad", 32'(perr_m), 32'h1);
    chk("par_vld", 32'(valid_m), 32'h1);
`endif

    // Reset mid-frame, between edges
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_busy", 32'(busy_m), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
